// File: rtl/gpio_debounce.sv
// Per-bit synchroniser and bounce filter for board switches: clean levels plus rise/fall strobes.
// Optional sticky pending flags and an interrupt output, enabled by the macro GPIO_DEBOUNCE_IRQ_EN.
module gpio_debounce #(
  parameter int unsigned     WIDTH           = 16,
  parameter int unsigned     SYNC_STAGES     = 2,
  parameter int unsigned     DEBOUNCE_CYCLES = 1000000,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
`ifdef GPIO_DEBOUNCE_IRQ_EN
  ,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] pend_o,
  output logic             irq_o
`endif
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  // A bit flips only after DEBOUNCE_CYCLES consecutive mismatching samples;
  // any matching sample in between restarts the count.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (s[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s[i];
          rise_d[i]   = s[i];
          fall_d[i]   = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      stable_q <= RESET_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

`ifdef GPIO_DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] pend_q;
  logic             irq_q;

  // Set has priority over write-1-to-clear in the same cycle.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~clr_i) | rise_q | fall_q;
      irq_q  <= |pend_q;
    end
  end

  assign pend_o = pend_q;
  assign irq_o  = irq_q;
`endif

endmodule

// File: doc/gpio_debounce.md
Name: gpio_debounce

Overview:
- Sits between the board switch pins and the GPIO input bus of the multiprocessor subsystem (mpss) on the NEXYS4-DDR top.
- Synchronises each raw switch bit into clk_i and filters mechanical bounce.
- Publishes a clean level vector plus one-cycle rise/fall strobes that firmware-visible GPIO logic samples.
- All bits are handled independently; there is no shared state between bits.

Parameters:
- WIDTH, 16, number of independent input bits.
- SYNC_STAGES, 2, flops in each bit's synchroniser chain; legal range is 2 or more.
- DEBOUNCE_CYCLES, 1000000, consecutive clk_i cycles a synchronised bit must differ from stable_o before stable_o flips. Legal range is 1 or more; 1000000 is 10 ms at 100 MHz.
- RESET_VAL, {WIDTH{1'b0}}, reset value of the synchroniser chain and stable_o.

Ports:
- clk_i  in  1  system clock.
- srst_i  in  1  reset; synchronous, active-high.
- raw_i  in  WIDTH  asynchronous switch inputs.
- stable_o  out  WIDTH  debounced levels; drives the GPIO input bus.
- rise_o  out  WIDTH  one-cycle pulse when the corresponding stable_o bit goes 0->1.
- fall_o  out  WIDTH  one-cycle pulse when the corresponding stable_o bit goes 1->0.

Behaviour:
- Reset (srst_i=1 at an edge): sync chain=RESET_VAL, stable_o=RESET_VAL, all counters=0, rise_o=fall_o=0. Reset mid-count discards any partial count; no strobe is emitted on reset.
- Synchroniser: raw_i passes through a SYNC_STAGES flop chain; s = last stage.
- Counter: one per bit, width $clog2(DEBOUNCE_CYCLES+1), unsigned, never wraps. For each bit i at every edge, with srst_i=0:
  - s[i]==stable_o[i]: cnt[i]<=0, no strobe.
  - s[i]!=stable_o[i] and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i]<=cnt[i]+1.
  - s[i]!=stable_o[i] and cnt[i]==DEBOUNCE_CYCLES-1: stable_o[i]<=s[i], cnt[i]<=0, rise_o[i] or fall_o[i] <=1 for exactly that cycle.
- Strobes: registered; asserted in the same cycle stable_o shows its new value; otherwise 0.
- Latency: for a clean step on raw_i held at least SYNC_STAGES+DEBOUNCE_CYCLES edges, stable_o changes at edge SYNC_STAGES+DEBOUNCE_CYCLES, counting the first edge that samples the new value as edge 1.
- Glitch: a mismatch run shorter than DEBOUNCE_CYCLES cycles resets the counter. stable_o is unchanged and no strobe is emitted.
- DEBOUNCE_CYCLES=1: stable_o follows s with a one-cycle delay.
- Multiple bits may flip and strobe in the same cycle.

Optional Feature:
- Macro GPIO_DEBOUNCE_IRQ_EN.
- When defined, the block adds these ports:
  - pend_o  out  WIDTH  sticky flags; pend_o[i] is set by rise_o[i]|fall_o[i].
  - clr_i  in  WIDTH  write-1-to-clear for pend_o.
  - irq_o  out  1  registered |pend_o.
- Set wins over clear in the same cycle. pend_o and irq_o reset to 0.
- When not defined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, WIDTH=16, RESET_VAL=0 unless stated):
- Reset: srst_i=1 for 3 cycles with raw_i=16'hFFFF -> stable_o=0, rise_o=fall_o=0 throughout. After release, stable_o=16'hFFFF at edge 6, with rise_o=16'hFFFF for that single cycle.
- Clean step: raw_i[3] 0->1 -> stable_o[3]=1 at edge 6, rise_o=16'h0008 for one cycle. Then 1->0 -> fall_o=16'h0008 for one cycle, 6 edges later.
- Bounce: raw_i[0] high for 3 cycles, low for 1, then high steady -> no change during the bounce. stable_o[0] rises exactly 6 edges after the final 0->1 edge.
- Simultaneous: raw_i 16'h0000->16'hA5A5 -> rise_o=16'hA5A5 in one cycle, stable_o=16'hA5A5.
- Reset mid-count: raw_i[7]=1, srst_i pulsed after 4 edges -> stable_o[7] stays 0, no strobe. stable_o[7]=1 at 6 edges after srst_i deasserts.
- GPIO_DEBOUNCE_IRQ_EN: rise on bit 2 -> pend_o=16'h0004, irq_o=1 one cycle later. clr_i=16'h0004 -> pend_o=0. clr_i concurrent with a new bit-2 strobe -> pend_o[2] stays 1.
